// File: rtl/baud_ctrl_pkg.sv
// Shared types and constants for the UART baud-tick controller.
package baud_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  // Smallest divisor that still yields a distinct tick period.
  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/prog_mod_counter.sv
// Up-counter with a runtime terminal count, synchronous clear and count enable.
// max_count is the last value before wrapping (modulus - 1), so a modulus of
// 2^W still fits in W bits.
module prog_mod_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] max_count,
  output logic [W-1:0] count,
  output logic         max_tick
);

  assign max_tick = (count == max_count);

  // Count up while enabled, wrap after max_count; reset/clear win over counting.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= max_tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/baud_rate_ctrl.sv
// UART baud-tick controller: programmable sample-tick divider plus a
// divide-by-OVS bit-tick stage. New divisors arrive over valid/ready and only
// take effect at a sample-counter wrap (or when the generator is stopped).
// Optional build macro BAUD_CTRL_SYNC_RESTART_EN: applying a pending divisor
// while running also restarts the oversample counter.
module baud_rate_ctrl #(
  parameter int unsigned N           = 8,
  parameter int unsigned DEFAULT_DIV = 163,
  parameter int unsigned OVS         = 16,
  parameter int unsigned OVS_W       = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_enable,
  input  logic         i_cfg_valid,
  input  logic [N-1:0] i_cfg_div,
  output logic         o_cfg_ready,
  output logic         o_cfg_err,
  output logic         o_sample_tick,
  output logic         o_bit_tick,
  output logic [N-1:0] o_cur_div,
  output logic         o_busy
);

  import baud_ctrl_pkg::*;

  state_e         state_q;
  logic [N-1:0]   cur_div_q;
  logic [N-1:0]   pend_div_q;
  logic           cfg_err_q;

  logic           cfg_ready;
  logic           xfer;
  logic           legal;
  logic           busy;

  logic [N-1:0]     cnt;
  logic [N-1:0]     cnt_max;
  logic             cnt_max_tick;
  logic             cnt_clear;
  logic             sample_tick;

  logic [OVS_W-1:0] ovs_cnt;
  logic [OVS_W-1:0] ovs_max;
  logic             ovs_max_tick;
  logic             ovs_clear;

  assign cfg_ready   = (state_q != ST_PEND);
  assign xfer        = i_cfg_valid & cfg_ready;
  assign legal       = (32'(i_cfg_div) >= MIN_DIV);
  assign busy        = (state_q != ST_IDLE);

  assign cnt_max     = cur_div_q - N'(1);
  assign ovs_max     = OVS_W'(OVS - 1);
  assign sample_tick = busy & cnt_max_tick;

  // Stopped or stopping: both counters return to zero on the next edge.
  assign cnt_clear   = (state_q == ST_IDLE) | ~i_enable;
`ifdef BAUD_CTRL_SYNC_RESTART_EN
  assign ovs_clear   = cnt_clear | ((state_q == ST_PEND) & sample_tick);
`else
  assign ovs_clear   = cnt_clear;
`endif

  prog_mod_counter #(
    .W (N)
  ) u_sample_cnt (
    .clk       (i_clk),
    .reset     (i_reset),
    .clear     (cnt_clear),
    .en        (busy),
    .max_count (cnt_max),
    .count     (cnt),
    .max_tick  (cnt_max_tick)
  );

  prog_mod_counter #(
    .W (OVS_W)
  ) u_ovs_cnt (
    .clk       (i_clk),
    .reset     (i_reset),
    .clear     (ovs_clear),
    .en        (sample_tick),
    .max_count (ovs_max),
    .count     (ovs_cnt),
    .max_tick  (ovs_max_tick)
  );

  // Control FSM: divisor register, pending slot and illegal-divisor flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cur_div_q  <= N'(DEFAULT_DIV);
      pend_div_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= xfer & ~legal;
      unique case (state_q)
        ST_IDLE: begin
          if (xfer && legal) cur_div_q <= i_cfg_div;
          if (i_enable) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!i_enable) begin
            // Stopping anyway, so a divisor offered now can be applied at once.
            if (xfer && legal) cur_div_q <= i_cfg_div;
            state_q <= ST_IDLE;
          end else if (xfer && legal) begin
            pend_div_q <= i_cfg_div;
            state_q    <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (!i_enable) begin
            cur_div_q <= pend_div_q;
            state_q   <= ST_IDLE;
          end else if (sample_tick) begin
            cur_div_q <= pend_div_q;
            state_q   <= ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Counters never run past the divisor in effect.
  a_cnt_range : assert property (@(posedge i_clk) disable iff (i_reset) cnt <= cnt_max);
  a_ovs_range : assert property (@(posedge i_clk) disable iff (i_reset) ovs_cnt <= ovs_max);

  assign o_cfg_ready   = cfg_ready;
  assign o_cfg_err     = cfg_err_q;
  assign o_sample_tick = sample_tick;
  assign o_bit_tick    = sample_tick & ovs_max_tick;
  assign o_cur_div     = cur_div_q;
  assign o_busy        = busy;

endmodule

// File: tb/tb_baud_rate_ctrl.sv
// Self-checking bench for baud_rate_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a cycle model of the spec.
// Honors BAUD_CTRL_SYNC_RESTART_EN the same way the design does.
module tb_baud_rate_ctrl;

  localparam int N   = 8;
  localparam int DEF = 163;
  localparam int OVS = 16;

  logic         clk;
  logic         rst;
  logic         en;
  logic         vld;
  logic [N-1:0] dv;
  logic         o_cfg_ready;
  logic         o_cfg_err;
  logic         o_sample_tick;
  logic         o_bit_tick;
  logic [N-1:0] o_cur_div;
  logic         o_busy;

  int n_checks = 0;
  int n_errors = 0;

  baud_rate_ctrl dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_cfg_valid   (vld),
    .i_cfg_div     (dv),
    .o_cfg_ready   (o_cfg_ready),
    .o_cfg_err     (o_cfg_err),
    .o_sample_tick (o_sample_tick),
    .o_bit_tick    (o_bit_tick),
    .o_cur_div     (o_cur_div),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec-level model: running flag, pending slot, position within the current
  // period and number of sample ticks since the bit phase was last restarted.
  typedef struct packed {
    bit run;
    bit pend;
    int div;
    int pdiv;
    int el;
    int nt;
    bit err;
  } model_t;

  model_t m;
  bit     m_ok = 1'b0;

  function automatic model_t step(model_t s, bit r, bit e, bit v, int d);
    model_t n;
    bit     tick, xfer, legal;
    n = s;
    if (r) begin
      n.run = 0; n.pend = 0; n.div = DEF; n.pdiv = 0; n.el = 0; n.nt = 0; n.err = 0;
      return n;
    end
    xfer  = v && !s.pend;
    legal = d >= 2;
    n.err = xfer && !legal;
    tick  = s.run && (s.el == s.div - 1);
    if (!s.run) begin
      if (xfer && legal) n.div = d;
      n.run = e; n.el = 0; n.nt = 0;
    end else if (!e) begin
      n.div = s.pend ? s.pdiv : ((xfer && legal) ? d : s.div);
      n.run = 0; n.pend = 0; n.el = 0; n.nt = 0;
    end else begin
      if (tick) begin
        n.el = 0;
        n.nt = s.nt + 1;
        if (s.pend) begin
          n.div  = s.pdiv;
          n.pend = 0;
`ifdef BAUD_CTRL_SYNC_RESTART_EN
          n.nt = 0;
`endif
        end
      end else begin
        n.el = s.el + 1;
      end
      if (xfer && legal) begin
        n.pend = 1;
        n.pdiv = d;
      end
    end
    return n;
  endfunction

  // Advance the model on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    m <= step(m, rst, en, vld, int'(dv));
    if (rst) m_ok <= 1'b1;
  end

  // Compare every DUT output against the model, away from the clock edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_ready", int'(o_cfg_ready), int'(!m.pend));
      chk("m_busy",  int'(o_busy),      int'(m.run));
      chk("m_div",   int'(o_cur_div),   m.div);
      chk("m_err",   int'(o_cfg_err),   int'(m.err));
      chk("m_tick",  int'(o_sample_tick), int'(m.run && (m.el == m.div - 1)));
      chk("m_bit",   int'(o_bit_tick),
          int'(m.run && (m.el == m.div - 1) && (m.nt % OVS == OVS - 1)));
    end
  end

  task automatic tick_gap(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!o_sample_tick && gap < 4000);
  endtask

  task automatic bit_gap(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!o_bit_tick && gap < 4000);
  endtask

  initial begin
    int g;
    int cnt;
    rst = 1'b1; en = 1'b0; vld = 1'b0; dv = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_ready", int'(o_cfg_ready), 1);
    chk("rst_div",   int'(o_cur_div),   163);
    chk("rst_busy",  int'(o_busy),      0);
    chk("rst_tick",  int'(o_sample_tick), 0);

    // 1: default divisor, sample and bit tick spacing
    rst = 1'b0; en = 1'b1;
    tick_gap(g); chk("t1_first_tick", g, 163);
    tick_gap(g); chk("t1_period", g, 163);
    bit_gap(g);  chk("t1_first_bit", g, 14 * 163);
    bit_gap(g);  chk("t1_bit_period", g, 2608);

    // 2: load 5 in IDLE, then run
    rst = 1'b1; en = 1'b0;
    @(negedge clk); rst = 1'b0; vld = 1'b1; dv = 8'd5;
    @(negedge clk); vld = 1'b0;
    chk("t2_div", int'(o_cur_div), 5);
    en = 1'b1;
    tick_gap(g); chk("t2_first", g, 5);
    tick_gap(g); chk("t2_period", g, 5);

    // 3: change 10 -> 4 while running, offered at cnt=3
    @(negedge clk); en = 1'b0;
    @(negedge clk); vld = 1'b1; dv = 8'd10;
    @(negedge clk); vld = 1'b0; en = 1'b1;
    repeat (4) @(negedge clk);
    vld = 1'b1; dv = 8'd4;
    @(negedge clk); vld = 1'b0;
    chk("t3_ready_low", int'(o_cfg_ready), 0);
    chk("t3_old_div",   int'(o_cur_div),   10);
    tick_gap(g); chk("t3_old_tick", g, 5);
    @(negedge clk);
    chk("t3_ready_high", int'(o_cfg_ready), 1);
    chk("t3_new_div",    int'(o_cur_div),   4);
    tick_gap(g); chk("t3_new_first", g, 3);
    tick_gap(g); chk("t3_new_period", g, 4);

    // 4: illegal divisor 1
    vld = 1'b1; dv = 8'd1;
    @(negedge clk); vld = 1'b0;
    chk("t4_err",   int'(o_cfg_err),   1);
    chk("t4_ready", int'(o_cfg_ready), 1);
    chk("t4_div",   int'(o_cur_div),   4);
    @(negedge clk);
    chk("t4_err_clr", int'(o_cfg_err), 0);
    tick_gap(g); chk("t4_phase", g, 2);
    tick_gap(g); chk("t4_period", g, 4);

    // 5: offer 7 on a wrap cycle, then stop while pending
    vld = 1'b1; dv = 8'd7;
    @(negedge clk); vld = 1'b0;
    chk("t5_pend_ready", int'(o_cfg_ready), 0);
    chk("t5_pend_div",   int'(o_cur_div),   4);
    en = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy", int'(o_busy),      0);
    chk("t5_idle_div",  int'(o_cur_div),   7);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_sample_tick) cnt++;
      @(negedge clk);
    end
    chk("t5_no_ticks", cnt, 0);
    en = 1'b1;
    tick_gap(g); chk("t5_first", g, 7);
    tick_gap(g); chk("t5_period", g, 7);

    // 6: reset while pending discards the pending divisor
    vld = 1'b1; dv = 8'd9;
    @(negedge clk); vld = 1'b0;
    chk("t6_pend", int'(o_cfg_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_div",   int'(o_cur_div),     163);
    chk("t6_ready", int'(o_cfg_ready),   1);
    chk("t6_busy",  int'(o_busy),        0);
    chk("t6_err",   int'(o_cfg_err),     0);
    chk("t6_tick",  int'(o_sample_tick), 0);
    chk("t6_bit",   int'(o_bit_tick),    0);
    rst = 1'b0;
    tick_gap(g); chk("t6_restart", g, 163);

    // Randomized traffic, checked cycle by cycle against the model
    repeat (4000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 999) < 3);
      en  = ($urandom_range(0, 99) < 95);
      vld = ($urandom_range(0, 99) < 6);
      dv  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255)) : N'($urandom_range(0, 12));
    end
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
